// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 registered mux/arbiter.
package mux_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first requester strictly after ptr, wrapping modulo CHANNELS.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    idx,
  output logic                vld
);

  logic [SEL_W-1:0] k;

  // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    k   = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      k = SEL_W'((int'(ptr) + i) % CHANNELS);
      if (req[k]) begin
        idx = k;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 mux with a single registered, handshaked output stage; explicit select or round-robin.
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter  int SIZE     = 32,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MUX_MODE_SEL,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CHANNELS*SIZE-1:0] data_i,
  input  logic [CHANNELS-1:0]      valid_i,
  output logic [CHANNELS-1:0]      ready_o,
  input  logic [SEL_W-1:0]         select_i,
  output logic [SIZE-1:0]          data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [SEL_W-1:0]         chan_o
);

  logic [SEL_W-1:0] g_idx;
  logic             g_vld;
  logic             load_en;
  logic             xfer_in;
  logic [SIZE-1:0]  sel_word;

  assign load_en = !valid_o || ready_i;
  assign xfer_in = !rst_i && load_en && g_vld;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SEL_W-1:0] ptr;
      logic             unused_sel;

      assign unused_sel = ^select_i;

      rr_pick #(.CHANNELS(CHANNELS)) u_pick (
        .req (valid_i),
        .ptr (ptr),
        .idx (g_idx),
        .vld (g_vld)
      );

      // Priority only rotates on an accepted word; idle/stalled cycles leave it alone.
      always_ff @(posedge clk_i) begin
        if (rst_i)        ptr <= SEL_W'(CHANNELS - 1);
        else if (xfer_in) ptr <= g_idx;
      end
    end else begin : g_sel
      // Out-of-range selects match no channel and so grant nothing.
      always_comb begin
        g_idx = select_i;
        g_vld = 1'b0;
        for (int k = 0; k < CHANNELS; k++)
          if (select_i == SEL_W'(k)) g_vld = valid_i[k];
      end
    end
  endgenerate

  always_comb begin
    ready_o = '0;
    if (xfer_in) ready_o[g_idx] = 1'b1;
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (g_idx == SEL_W'(k)) sel_word = data_i[k*SIZE +: SIZE];
  end

  // Load wins over drain, so a same-cycle in/out keeps valid_o high with no bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      chan_o  <= '0;
    end else if (xfer_in) begin
      valid_o <= 1'b1;
      data_o  <= sel_word;
      chan_o  <= g_idx;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench: dut0 select 4ch, dut1 select 3ch, dut2 round-robin 4ch; directed table then random vs model.
module tb_mux_arb_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] data0, data2;
  logic [95:0]  data1;
  logic [3:0]   vi0, vi2, ro0, ro2;
  logic [2:0]   vi1, ro1;
  logic [1:0]   sel0, sel1, sel2, co0, co1, co2;
  logic         ri0, ri1, ri2, vo0, vo1, vo2;
  logic [31:0]  do0, do1, do2;

  mux_arb_nto1 #(.SIZE(32), .CHANNELS(4), .MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .data_i(data0), .valid_i(vi0), .ready_o(ro0),
    .select_i(sel0), .data_o(do0), .valid_o(vo0), .ready_i(ri0), .chan_o(co0));
  mux_arb_nto1 #(.SIZE(32), .CHANNELS(3), .MODE(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data1), .valid_i(vi1), .ready_o(ro1),
    .select_i(sel1), .data_o(do1), .valid_o(vo1), .ready_i(ri1), .chan_o(co1));
  mux_arb_nto1 #(.SIZE(32), .CHANNELS(4), .MODE(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .data_i(data2), .valid_i(vi2), .ready_o(ro2),
    .select_i(sel2), .data_o(do2), .valid_o(vo2), .ready_i(ri2), .chan_o(co2));

  int checks = 0;
  int failures = 0;

  // Stimulus/model state, per dut
  bit        mrst;
  bit [31:0] mdata [3][4];
  bit [3:0]  mvld [3];
  int        msel [3];
  bit        mrdy [3];
  bit        ev [3];
  bit [31:0] ed [3];
  int        ec [3];
  int        ptr [3];
  int        gr [3];
  bit [3:0]  pre_ro [3];

  typedef struct {
    bit        rst;
    int        dut;
    bit [3:0]  vld;
    int        sel;
    bit        rdy;
    bit [3:0]  er;
    bit        ev;
    bit [31:0] ed;
    int        ec;
  } vec_t;
  vec_t tbl [$];

  function automatic int nch(int d);
    return (d == 1) ? 3 : 4;
  endfunction

  // Spec-level grant: explicit select or first requester after ptr (modulo channel count).
  function automatic int grant(int d);
    int c;
    c = nch(d);
    if (d != 2) return (msel[d] < c && mvld[d][msel[d]]) ? msel[d] : -1;
    for (int i = 1; i <= c; i++)
      if (mvld[d][(ptr[d] + i) % c]) return (ptr[d] + i) % c;
    return -1;
  endfunction

  function automatic bit [3:0] act_ro(int d);
    return (d == 0) ? ro0 : (d == 1) ? {1'b0, ro1} : ro2;
  endfunction
  function automatic bit act_vo(int d);
    return (d == 0) ? vo0 : (d == 1) ? vo1 : vo2;
  endfunction
  function automatic bit [31:0] act_do(int d);
    return (d == 0) ? do0 : (d == 1) ? do1 : do2;
  endfunction
  function automatic int act_co(int d);
    return (d == 0) ? int'(co0) : (d == 1) ? int'(co1) : int'(co2);
  endfunction

  task automatic chk(input string nm, input int d, input bit [31:0] act, input bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic drive();
    rst = mrst;
    for (int k = 0; k < 4; k++) begin
      data0[k*32 +: 32] = mdata[0][k];
      data2[k*32 +: 32] = mdata[2][k];
    end
    for (int k = 0; k < 3; k++) data1[k*32 +: 32] = mdata[1][k];
    vi0 = mvld[0]; vi1 = mvld[1][2:0]; vi2 = mvld[2];
    sel0 = 2'(msel[0]); sel1 = 2'(msel[1]); sel2 = 2'(msel[2]);
    ri0 = mrdy[0]; ri1 = mrdy[1]; ri2 = mrdy[2];
  endtask

  // One cycle: check ready_o before the edge, advance model, check outputs after.
  task automatic step();
    bit [3:0] er;
    drive();
    #1;
    for (int d = 0; d < 3; d++) begin
      gr[d] = grant(d);
      er = (!mrst && (!ev[d] || mrdy[d]) && gr[d] >= 0) ? 4'(1 << gr[d]) : 4'd0;
      pre_ro[d] = act_ro(d);
      chk("ready_o", d, 32'(pre_ro[d]), 32'(er));
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (mrst) begin
        ev[d] = 1'b0; ed[d] = '0; ec[d] = 0; ptr[d] = nch(d) - 1;
      end else if ((!ev[d] || mrdy[d]) && gr[d] >= 0) begin
        ev[d] = 1'b1; ed[d] = mdata[d][gr[d]]; ec[d] = gr[d];
        if (d == 2) ptr[d] = gr[d];
      end else if (ev[d] && mrdy[d]) begin
        ev[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("valid_o", d, 32'(act_vo(d)), 32'(ev[d]));
      chk("data_o", d, act_do(d), ed[d]);
      chk("chan_o", d, 32'(act_co(d)), 32'(ec[d]));
    end
  endtask

  task automatic add(input bit r, input int d, input bit [3:0] v, input int s, input bit rd,
                     input bit [3:0] er, input bit e_v, input bit [31:0] e_d, input int e_c);
    tbl.push_back('{r, d, v, s, rd, er, e_v, e_d, e_c});
  endtask

  initial begin
    mdata[0][0] = 32'hAAAA; mdata[0][1] = 32'hBBBB;
    mdata[0][2] = 32'hCCCC; mdata[0][3] = 32'hDDDD;
    for (int k = 0; k < 4; k++) begin
      mdata[1][k] = 32'h1110 + 32'(k);
      mdata[2][k] = 32'h2000 + 32'(k);
    end
    for (int d = 0; d < 3; d++) begin
      ev[d] = 0; ed[d] = 0; ec[d] = 0; ptr[d] = nch(d) - 1;
    end

    add(1, 0, 4'hF, 2, 1, 4'b0000, 0, 32'h0,    0);
    add(0, 0, 4'hF, 2, 1, 4'b0100, 1, 32'hCCCC, 2);
    add(0, 0, 4'h0, 2, 1, 4'b0000, 0, 32'hCCCC, 2);
    add(0, 1, 4'h7, 3, 1, 4'b0000, 0, 32'h0,    0);
    add(0, 1, 4'h5, 1, 1, 4'b0000, 0, 32'h0,    0);
    add(0, 1, 4'h7, 1, 0, 4'b0010, 1, 32'h1111, 1);
    add(0, 1, 4'h7, 0, 0, 4'b0000, 1, 32'h1111, 1);
    add(0, 1, 4'h7, 0, 1, 4'b0001, 1, 32'h1110, 0);
    for (int i = 0; i < 8; i++)
      add(0, 2, 4'hF, 0, 1, 4'(1 << (i % 4)), 1, 32'h2000 + 32'(i % 4), i % 4);
    add(0, 2, 4'h0, 0, 1, 4'b0000, 0, 32'h2003, 3);
    add(0, 2, 4'hA, 0, 0, 4'b0010, 1, 32'h2001, 1);
    add(0, 2, 4'hA, 0, 0, 4'b0000, 1, 32'h2001, 1);
    add(0, 2, 4'hA, 0, 0, 4'b0000, 1, 32'h2001, 1);
    add(0, 2, 4'hA, 0, 1, 4'b1000, 1, 32'h2003, 3);
    add(0, 2, 4'hA, 0, 1, 4'b0010, 1, 32'h2001, 1);
    add(1, 2, 4'hF, 0, 0, 4'b0000, 0, 32'h0,    0);
    add(0, 2, 4'hC, 0, 1, 4'b0100, 1, 32'h2002, 2);

    foreach (tbl[i]) begin
      for (int d = 0; d < 3; d++) begin
        mvld[d] = '0; msel[d] = 0; mrdy[d] = 1'b1;
      end
      mrst = tbl[i].rst;
      mvld[tbl[i].dut] = tbl[i].vld;
      msel[tbl[i].dut] = tbl[i].sel;
      mrdy[tbl[i].dut] = tbl[i].rdy;
      step();
      chk("vec_ready", tbl[i].dut, 32'(pre_ro[tbl[i].dut]), 32'(tbl[i].er));
      chk("vec_valid", tbl[i].dut, 32'(act_vo(tbl[i].dut)), 32'(tbl[i].ev));
      chk("vec_data", tbl[i].dut, act_do(tbl[i].dut), tbl[i].ed);
      chk("vec_chan", tbl[i].dut, 32'(act_co(tbl[i].dut)), 32'(tbl[i].ec));
    end

    for (int n = 0; n < 500; n++) begin
      mrst = ($urandom_range(0, 49) == 0);
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 4; k++) mdata[d][k] = $urandom;
        mvld[d] = 4'($urandom) & ((d == 1) ? 4'h7 : 4'hF);
        msel[d] = $urandom_range(0, 3);
        mrdy[d] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
